// File: rtl/stopwatch_mux_display_pkg.sv
// Shared types, 7-segment patterns and decode helper for the stopwatch display slice.
// Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package stopwatch_mux_display_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_D0    = 7'h40;
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_D5    = 7'h12;
  localparam logic [6:0] SEG_D6    = 7'h02;
  localparam logic [6:0] SEG_D7    = 7'h78;
  localparam logic [6:0] SEG_D8    = 7'h00;
  localparam logic [6:0] SEG_D9    = 7'h10;

  function automatic logic [6:0] seg_decode(input bcd_t d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_D0;
      4'd1:    p = SEG_D1;
      4'd2:    p = SEG_D2;
      4'd3:    p = SEG_D3;
      4'd4:    p = SEG_D4;
      4'd5:    p = SEG_D5;
      4'd6:    p = SEG_D6;
      4'd7:    p = SEG_D7;
      4'd8:    p = SEG_D8;
      4'd9:    p = SEG_D9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/stopwatch_mux_display_btn_debounce.sv
// Button debouncer: the level follows raw only after raw has disagreed with it for
// DEBOUNCE_CYC consecutive cycles; press is a one-cycle pulse on each new 0->1 level.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          press_r;

  // any sample equal to the current level restarts the stability count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else if (raw == level_r) begin
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      level_r <= raw;
      press_r <= raw;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      press_r <= 1'b0;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/stopwatch_mux_display.sv
// N-digit BCD stopwatch / countdown timer with lap freeze and a multiplexed,
// active-low 7-segment display driven straight onto board pins.
module stopwatch_mux_display
  import stopwatch_mux_display_pkg::*;
#(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          TICK_HZ      = 100,
  parameter int          SCAN_HZ      = 1000,
  parameter int          N_DIGITS     = 4,
  parameter int          DP_POS       = 2,
  parameter int          DEBOUNCE_CYC = 500_000,
  parameter int          COUNT_DOWN   = 0,
  parameter logic [31:0] PRELOAD      = 32'h0000_6000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_start,
  input  logic                btn_clear,
  input  logic                btn_lap,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                seg_p,
  output logic                led_run,
  output logic                led_flag
);
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int W        = N_DIGITS * 4;
  localparam int PW       = $clog2(DIV);
  localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam bit DOWN     = (COUNT_DOWN != 0);

  localparam logic [W-1:0]  RELOAD     = DOWN ? PRELOAD[W-1:0] : '0;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  logic          start_ev_s, clear_ev_s, lap_ev_s;
  logic [2:0]    db_level_unused_s;
  logic          run_r, run_nx_s, lap_r, flag_r;
  logic [PW-1:0] presc_r;
  logic [W-1:0]  count_r, disp_r, count_nx_s;
  logic [N_DIGITS-1:0] roll_s, carry_s;
  logic          tick_s, wrap_s, zero_nx_s, hit_s;
  logic [SW-1:0] scnt_r;
  logic [IW-1:0] idx_r;
  bcd_t          cur_digit_s;
  logic          dp_hit_s;
  logic [N_DIGITS-1:0] an_r;
  logic [6:0]    seg_r;
  logic          segp_r;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
    .clk(clk), .rst_n(rst_n), .raw(btn_start), .level(db_level_unused_s[0]), .press(start_ev_s));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clear (
    .clk(clk), .rst_n(rst_n), .raw(btn_clear), .level(db_level_unused_s[1]), .press(clear_ev_s));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lap (
    .clk(clk), .rst_n(rst_n), .raw(btn_lap), .level(db_level_unused_s[2]), .press(lap_ev_s));

  assign tick_s = run_r & (presc_r == PRESC_LAST);

  // Each digit steps only when every lower digit rolls (9 going up, 0 going down);
  // carry is formed from a mask rather than a ripple chain.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_t d_s;
    assign d_s        = count_r[g*4 +: 4];
    assign roll_s[g]  = DOWN ? (d_s == 4'd0) : (d_s == 4'd9);
    assign carry_s[g] = &(roll_s | ~N_DIGITS'((1 << g) - 1));
    assign count_nx_s[g*4 +: 4] = !carry_s[g] ? d_s :
                                  roll_s[g]   ? (DOWN ? 4'd9 : 4'd0) :
                                  DOWN        ? d_s - 4'd1 : d_s + 4'd1;
  end

  assign wrap_s    = &roll_s;
  assign zero_nx_s = (count_nx_s == '0);
  assign hit_s     = tick_s & (DOWN ? zero_nx_s : wrap_s);

  // expiry stops the countdown; a start press at zero in down mode is ignored
  always_comb begin
    if (tick_s && DOWN && zero_nx_s) begin
      run_nx_s = 1'b0;
    end else if (start_ev_s && !(DOWN && (count_r == '0))) begin
      run_nx_s = ~run_r;
    end else begin
      run_nx_s = run_r;
    end
  end

  // run control, prescaler, BCD count, lap freeze and sticky flag; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r   <= 1'b0;
      presc_r <= '0;
      count_r <= RELOAD;
      lap_r   <= 1'b0;
      disp_r  <= RELOAD;
      flag_r  <= 1'b0;
    end else if (clear_ev_s) begin
      run_r   <= 1'b0;
      presc_r <= '0;
      count_r <= RELOAD;
      lap_r   <= 1'b0;
      disp_r  <= RELOAD;
      flag_r  <= 1'b0;
    end else begin
      run_r   <= run_nx_s;
      presc_r <= !run_r ? presc_r : (presc_r == PRESC_LAST) ? '0 : presc_r + PW'(1);
      count_r <= tick_s ? count_nx_s : count_r;
      lap_r   <= lap_r ^ lap_ev_s;
      disp_r  <= (lap_r && !lap_ev_s) ? disp_r : count_r;
      flag_r  <= flag_r | hit_s;
    end
  end

  // digit scan free-runs independently of the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_r <= '0;
      idx_r  <= '0;
    end else if (scnt_r == SCAN_LAST) begin
      scnt_r <= '0;
      idx_r  <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
    end else begin
      scnt_r <= scnt_r + SW'(1);
    end
  end

  assign cur_digit_s = disp_r[{idx_r, 2'b00} +: 4];
  assign dp_hit_s    = (DP_POS >= 0) && (DP_POS < N_DIGITS) && (idx_r == IW'(DP_POS));

  // registered pin drivers, one cycle behind the scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r   <= '1;
      seg_r  <= SEG_BLANK;
      segp_r <= 1'b1;
    end else begin
      an_r   <= ~(N_DIGITS'(1) << idx_r);
      seg_r  <= seg_decode(cur_digit_s);
      segp_r <= ~dp_hit_s;
    end
  end

  assign an       = an_r;
  assign seg      = seg_r;
  assign seg_p    = segp_r;
  assign led_run  = run_r;
  assign led_flag = flag_r;

endmodule

// File: tb/tb_stopwatch_mux_display.sv
// Bench for stopwatch_mux_display: three configurations (4-digit up, 2-digit up, 4-digit down)
// share one button stimulus and are compared every cycle against a decimal-arithmetic model.
module tb_stopwatch_mux_display;
  localparam int DIV = 10;
  localparam int SDIV = 4;
  localparam int DEB = 3;
  localparam int DP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_start = 1'b0;
  logic btn_clear = 1'b0;
  logic btn_lap = 1'b0;

  logic [3:0] an_u, an_d;
  logic [1:0] an_w;
  logic [6:0] seg_u, seg_w, seg_d;
  logic segp_u, segp_w, segp_d, run_u, run_w, run_d, flag_u, flag_w, flag_d;

  always #5 clk = ~clk;

  stopwatch_mux_display #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250), .N_DIGITS(4), .DP_POS(2),
    .DEBOUNCE_CYC(3), .COUNT_DOWN(0), .PRELOAD(32'h0000_6000)) u_up (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .an(an_u), .seg(seg_u), .seg_p(segp_u), .led_run(run_u), .led_flag(flag_u));

  stopwatch_mux_display #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250), .N_DIGITS(2), .DP_POS(2),
    .DEBOUNCE_CYC(3), .COUNT_DOWN(0), .PRELOAD(32'h0000_0000)) u_w (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .an(an_w), .seg(seg_w), .seg_p(segp_w), .led_run(run_w), .led_flag(flag_w));

  stopwatch_mux_display #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250), .N_DIGITS(4), .DP_POS(2),
    .DEBOUNCE_CYC(3), .COUNT_DOWN(1), .PRELOAD(32'h0000_0003)) u_dn (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .an(an_d), .seg(seg_d), .seg_p(segp_d), .led_run(run_d), .led_flag(flag_d));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int nd [3] = '{4, 2, 4};
  bit dn [3] = '{1'b0, 1'b0, 1'b1};
  int rl [3] = '{0, 0, 3};
  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bit hist [3][DEB];
  bit lvl [3];
  bit prs [3];
  int m_run [3], m_presc [3], m_val [3], m_lap [3], m_disp [3], m_flag [3];
  int m_idx [3], m_an [3], m_seg [3], m_segp [3];
  int m_scnt;

  function automatic int p10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      lvl[j] = 1'b0;
      prs[j] = 1'b0;
      for (int h = 0; h < DEB; h++) hist[j][h] = 1'b0;
    end
    m_scnt = 0;
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 0; m_presc[k] = 0; m_val[k] = rl[k]; m_lap[k] = 0; m_disp[k] = rl[k];
      m_flag[k] = 0; m_idx[k] = 0; m_an[k] = (1 << nd[k]) - 1; m_seg[k] = 32'h7F; m_segp[k] = 1;
    end
  endtask

  task automatic model_step();
    bit raw [3];
    bit ev [3];
    bit flip, tick, hit;
    int nv, nr, md;
    raw[0] = btn_start; raw[1] = btn_clear; raw[2] = btn_lap;
    for (int j = 0; j < 3; j++) ev[j] = prs[j];
    // a button's level flips once its last DEB samples all disagree with it
    for (int j = 0; j < 3; j++) begin
      for (int h = DEB - 1; h > 0; h--) hist[j][h] = hist[j][h-1];
      hist[j][0] = raw[j];
      flip = 1'b1;
      for (int h = 0; h < DEB; h++) if (hist[j][h] == lvl[j]) flip = 1'b0;
      prs[j] = 1'b0;
      if (flip) begin
        lvl[j] = ~lvl[j];
        prs[j] = lvl[j];
      end
    end
    for (int k = 0; k < 3; k++) begin
      md = p10(nd[k]);
      m_an[k]   = ((1 << nd[k]) - 1) & ~(1 << m_idx[k]);
      m_seg[k]  = 32'(segtab[(m_disp[k] / p10(m_idx[k])) % 10]);
      m_segp[k] = (m_idx[k] == DP) ? 0 : 1;
      tick = (m_run[k] != 0) && (m_presc[k] == DIV - 1);
      if (ev[1]) begin
        m_run[k] = 0; m_presc[k] = 0; m_val[k] = rl[k]; m_lap[k] = 0; m_disp[k] = rl[k]; m_flag[k] = 0;
      end else begin
        hit = 1'b0;
        nv = m_val[k];
        if (tick) begin
          if (dn[k]) begin
            nv = m_val[k] - 1;
            hit = (nv == 0);
          end else begin
            nv = (m_val[k] + 1) % md;
            hit = (m_val[k] == md - 1);
          end
        end
        nr = m_run[k];
        if (ev[0] && !(dn[k] && m_val[k] == 0)) nr = 1 - m_run[k];
        if (dn[k] && hit) nr = 0;
        if (m_run[k] != 0) m_presc[k] = (m_presc[k] + 1) % DIV;
        if (hit) m_flag[k] = 1;
        if (!(m_lap[k] != 0 && !ev[2])) m_disp[k] = m_val[k];
        if (ev[2]) m_lap[k] = 1 - m_lap[k];
        m_val[k] = nv;
        m_run[k] = nr;
      end
      if (m_scnt == SDIV - 1) m_idx[k] = (m_idx[k] + 1) % nd[k];
    end
    m_scnt = (m_scnt + 1) % SDIV;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk_eq("up.an", 32'(an_u), m_an[0]);
    chk_eq("up.seg", 32'(seg_u), m_seg[0]);
    chk_eq("up.seg_p", 32'(segp_u), m_segp[0]);
    chk_eq("up.led_run", 32'(run_u), m_run[0]);
    chk_eq("up.led_flag", 32'(flag_u), m_flag[0]);
    chk_eq("w2.an", 32'(an_w), m_an[1]);
    chk_eq("w2.seg", 32'(seg_w), m_seg[1]);
    chk_eq("w2.seg_p", 32'(segp_w), m_segp[1]);
    chk_eq("w2.led_run", 32'(run_w), m_run[1]);
    chk_eq("w2.led_flag", 32'(flag_w), m_flag[1]);
    chk_eq("dn.an", 32'(an_d), m_an[2]);
    chk_eq("dn.seg", 32'(seg_d), m_seg[2]);
    chk_eq("dn.seg_p", 32'(segp_d), m_segp[2]);
    chk_eq("dn.led_run", 32'(run_d), m_run[2]);
    chk_eq("dn.led_flag", 32'(flag_d), m_flag[2]);
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int cyc);
    repeat (cyc) @(negedge clk);
  endtask

  task automatic hold(input bit s, input bit c, input bit l, input int cyc);
    btn_start = s; btn_clear = c; btn_lap = l;
    repeat (cyc) @(negedge clk);
    btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
  endtask

  initial begin
    int r;
    model_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    chk_eq("rst.an_up", 32'(an_u), 32'h0000_000F);
    chk_eq("rst.an_w2", 32'(an_w), 32'h0000_0003);
    chk_eq("rst.seg", 32'(seg_u), 32'h0000_007F);
    chk_eq("rst.seg_p", 32'(segp_u), 32'h0000_0001);
    chk_eq("rst.led_run", 32'(run_u), 32'h0000_0000);
    chk_eq("rst.led_flag", 32'(flag_d), 32'h0000_0000);

    // idle scan, then a 2-cycle glitch that must not start the count
    idle(40);
    hold(1'b1, 1'b0, 1'b0, 2);
    idle(10);
    chk_eq("glitch.led_run", 32'(run_u), 32'h0000_0000);

    // clean start press: run rises on the fourth edge after the press begins
    btn_start = 1'b1;
    idle(3);
    chk_eq("start.pre_run", 32'(run_u), 32'h0000_0000);
    idle(1);
    chk_eq("start.led_run", 32'(run_u), 32'h0000_0001);
    idle(1);
    btn_start = 1'b0;

    // lap freeze and release while counting continues
    idle(230);
    hold(1'b0, 1'b0, 1'b1, 4);
    idle(150);
    hold(1'b0, 1'b0, 1'b1, 4);
    idle(20);

    // long run: 2-digit unit wraps, countdown expires, start at zero is ignored
    hold(1'b0, 1'b1, 1'b0, 4);
    idle(3);
    hold(1'b1, 1'b0, 1'b0, 4);
    idle(1100);
    chk_eq("wrap.flag_w2", 32'(flag_w), 32'h0000_0001);
    chk_eq("wrap.run_w2", 32'(run_w), 32'h0000_0001);
    chk_eq("wrap.flag_up", 32'(flag_u), 32'h0000_0000);
    chk_eq("expire.flag_dn", 32'(flag_d), 32'h0000_0001);
    chk_eq("expire.run_dn", 32'(run_d), 32'h0000_0000);
    hold(1'b1, 1'b0, 1'b0, 4);
    idle(3);
    chk_eq("expire.start_ignored", 32'(run_d), 32'h0000_0000);
    hold(1'b0, 1'b1, 1'b0, 4);
    idle(2);
    chk_eq("clear.flag_w2", 32'(flag_w), 32'h0000_0000);
    chk_eq("clear.flag_dn", 32'(flag_d), 32'h0000_0000);

    // clear and start debounced in the same cycle: clear wins
    hold(1'b1, 1'b0, 1'b0, 4);
    idle(50);
    hold(1'b1, 1'b1, 1'b0, 4);
    idle(2);
    chk_eq("clr_start.led_run", 32'(run_u), 32'h0000_0000);

    // randomized button traffic, including short bounces and overlapping presses
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) hold(1'b1, 1'b0, 1'b0, int'($urandom_range(3, 6)));
      else if (r < 70) hold(1'b0, 1'b0, 1'b1, int'($urandom_range(3, 6)));
      else if (r < 78) hold(1'b0, 1'b1, 1'b0, int'($urandom_range(3, 6)));
      else if (r < 88) hold(1'b1, 1'b0, 1'b1, int'($urandom_range(3, 6)));
      else hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(1, 2)));
      idle(int'($urandom_range(1, 60)));
    end

    // asynchronous reset mid-count, asserted away from the clock edge
    hold(1'b0, 1'b1, 1'b0, 4);
    idle(2);
    hold(1'b1, 1'b0, 1'b0, 4);
    idle(60);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst.an", 32'(an_u), 32'h0000_000F);
    chk_eq("arst.seg", 32'(seg_u), 32'h0000_007F);
    chk_eq("arst.seg_p", 32'(segp_u), 32'h0000_0001);
    chk_eq("arst.led_run", 32'(run_u), 32'h0000_0000);
    chk_eq("arst.led_flag", 32'(flag_u), 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
